// File: rtl/ultra_ranger_mc.sv
// Multi-channel HC-SR04 ranger: round-robin trigger, synchronised echo timing,
// BCD centimetre result per channel with echo-timeout flagging.
module ultra_ranger_mc #(
    parameter int CLK_MHZ = 12,
    parameter int CH      = 2,
    parameter int DIG     = 4,
    parameter int TRIG_US = 10,
    parameter int GAP_MS  = 60,
    parameter int MAX_CM  = 400
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [CH-1:0]                        echo,
    output logic [CH-1:0]                        trig,
    output logic [CH*4*DIG-1:0]                  dist_bcd,
    output logic                                 dist_vld,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] dist_ch,
    output logic [CH-1:0]                        err
);

    localparam int CW       = (CH > 1) ? $clog2(CH) : 1;
    localparam int CM_CYC   = 58 * CLK_MHZ;
    localparam int GAP_CYC  = GAP_MS * 1000 * CLK_MHZ;
    localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
    localparam int TO_CYC   = MAX_CM * CM_CYC;
    localparam int TMAX1    = (GAP_CYC > TO_CYC) ? GAP_CYC : TO_CYC;
    localparam int TMAX     = (TMAX1 > TRIG_CYC) ? TMAX1 : TRIG_CYC;
    localparam int TW       = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TRIG_END = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0] TO_END   = TW'(TO_CYC);
    localparam logic [TW-1:0] CM_END   = TW'(CM_CYC - 1);

    function automatic logic [4*DIG-1:0] to_bcd(input int unsigned v);
        logic [4*DIG-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < DIG; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [4*DIG-1:0] MAX_BCD = to_bcd(MAX_CM);
    localparam logic [4*DIG-1:0] ALL9    = {DIG{4'h9}};

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

    state_t          state, nstate;
    logic [CW-1:0]   cur;
    logic [TW-1:0]   tmr;
    logic [4*DIG-1:0] bcd, bcd_inc;
    logic            tout;
    logic [CH-1:0]   sync1, sync2, sync3, rise, fall;
    logic            rise_c, fall_c, carry, done;
    logic [CH-1:0]   trig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    always_comb begin
        rise_c = 1'b0;
        fall_c = 1'b0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (cur == CW'(k)) begin
                rise_c = rise[k];
                fall_c = fall[k];
            end
        end
    end

    // Decimal increment with the full carry chain resolved in one cycle
    always_comb begin
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int unsigned i = 0; i < DIG; i++) begin
            if (carry) begin
                if (bcd[i*4 +: 4] == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[i*4 +: 4] = bcd[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:      if (tmr == GAP_END && en) nstate = TRIG;
            TRIG:      if (tmr == TRIG_END) nstate = WAIT_RISE;
            WAIT_RISE: if (rise_c || tmr == TO_END) nstate = rise_c ? MEASURE : DONE;
            MEASURE:   if ((tmr == CM_END && bcd == MAX_BCD) || fall_c) nstate = DONE;
            DONE:      nstate = IDLE;
            default:   nstate = IDLE;
        endcase
    end

    always_comb begin
        trig_d = '0;
        done   = (state == DONE);
        if (state == TRIG) begin
            for (int unsigned k = 0; k < CH; k++) trig_d[k] = (cur == CW'(k));
        end
    end

    // A wrap coinciding with the falling edge still counts, so DONE sees the updated count
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr  <= '0;
            bcd  <= '0;
            tout <= 1'b0;
            cur  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tmr != GAP_END) tmr <= tmr + 1'b1;
                    else if (en)        tmr <= '0;
                end
                TRIG: begin
                    tout <= 1'b0;
                    tmr  <= (tmr == TRIG_END) ? '0 : tmr + 1'b1;
                end
                WAIT_RISE: begin
                    if (rise_c) begin
                        tmr <= '0;
                        bcd <= '0;
                    end else if (tmr == TO_END) begin
                        tout <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                MEASURE: begin
                    if (tmr == CM_END) begin
                        tmr <= '0;
                        if (bcd == MAX_BCD) tout <= 1'b1;
                        else                bcd  <= bcd_inc;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                DONE: begin
                    tmr <= '0;
                    cur <= (cur == CW'(CH - 1)) ? '0 : cur + 1'b1;
                end
                default: tmr <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig     <= '0;
            dist_vld <= 1'b0;
            dist_ch  <= '0;
            dist_bcd <= '0;
            err      <= '0;
        end else begin
            trig     <= trig_d;
            dist_vld <= done;
            if (done) begin
                dist_ch <= cur;
                for (int unsigned k = 0; k < CH; k++) begin
                    if (cur == CW'(k)) begin
                        dist_bcd[k*4*DIG +: 4*DIG] <= tout ? ALL9 : bcd;
                        err[k]                     <= tout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ultra_ranger_mc.sv
// Bench for ultra_ranger_mc: directed scenarios plus randomized echo widths,
// checked against a width-to-centimetre reference model.
module tb_ultra_ranger_mc;

    localparam int CLK_MHZ = 1, CH = 2, DIG = 2, TRIG_US = 10, GAP_MS = 1, MAX_CM = 20;
    localparam int CM_CYC   = 58 * CLK_MHZ;
    localparam int GAP_CYC  = GAP_MS * 1000 * CLK_MHZ;
    localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
    localparam int TO_CYC   = MAX_CM * CM_CYC;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en  = 1'b1;
    logic [CH-1:0]          echo = '0;
    logic [CH-1:0]          trig;
    logic [CH*4*DIG-1:0]    dist_bcd;
    logic                   dist_vld;
    logic [0:0]             dist_ch;
    logic [CH-1:0]          err;

    ultra_ranger_mc #(
        .CLK_MHZ(CLK_MHZ), .CH(CH), .DIG(DIG),
        .TRIG_US(TRIG_US), .GAP_MS(GAP_MS), .MAX_CM(MAX_CM)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig),
        .dist_bcd(dist_bcd), .dist_vld(dist_vld), .dist_ch(dist_ch), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cm [CH];     // -1 marks a timeout result
    int vld_cnt = 0, trig_rises = 0, multi_hot = 0;
    logic [CH-1:0] prev_trig = '0;

    always @(negedge clk) begin
        if (dist_vld) vld_cnt++;
        if ((trig & (trig - 2'd1)) != '0) multi_hot++;
        if (trig != '0 && prev_trig == '0) trig_rises++;
        prev_trig = trig;
    end

    function automatic logic [7:0] bcd_of(input int cm);
        if (cm < 0) return 8'h99;
        return 8'((cm / 10) * 16 + cm % 10);
    endfunction

    function automatic int cm_of_width(input int w);
        if (w == 0 || w / CM_CYC > MAX_CM) return -1;
        return w / CM_CYC;
    endfunction

    function automatic logic [7:0] fld(input int k);
        return dist_bcd[k*8 +: 8];
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        step();
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        for (int k = 0; k < CH; k++) exp_cm[k] = 0;
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (trig == '0 && n < 6000) begin step(); n++; end
    endtask

    // Waits for a trigger pulse, then drives a w-cycle echo on ch (w=0: none).
    // lat counts cycles from trig falling to the result strobe.
    task automatic run_echo(input int ch, input int w, input bit xt,
                            output int lat, output int tw, output int nv);
        int v0, n, oth;
        v0  = vld_cnt;
        oth = (ch == 0) ? 1 : 0;
        n = 0;
        while (trig == '0 && n < 6000) begin step(); n++; end
        tw = 0;
        while (trig != '0 && tw < 100) begin step(); tw++; end
        lat = 0;
        if (w > 0) begin
            step(); lat++;
            echo[ch] = 1'b1;
            for (int i = 0; i < w; i++) begin
                step(); lat++;
                if (xt) echo[oth] = 1'($urandom_range(0, 1));
            end
            echo[ch] = 1'b0;
            if (xt) echo[oth] = 1'b0;
        end
        while (vld_cnt == v0 && lat < 4000) begin step(); lat++; end
        nv = vld_cnt - v0;
        exp_cm[ch] = cm_of_width(w);
    endtask

    task automatic test_reset();
        int n;
        do_reset(3);
        checks++; if (trig !== '0) begin errors++; $display("FAIL reset_trig got %b exp 00", trig); end
        checks++; if (dist_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", dist_vld); end
        checks++; if (dist_bcd !== '0) begin errors++; $display("FAIL reset_bcd got %h exp 0000", dist_bcd); end
        checks++; if (err !== '0 || dist_ch !== 1'b0) begin errors++; $display("FAIL reset_err_ch got err=%b ch=%b exp 00/0", err, dist_ch); end
        wait_trig(n);
        checks++; if (n !== GAP_CYC + 1 || trig !== 2'b01) begin errors++; $display("FAIL reset_first_trig got n=%0d trig=%b exp n=%0d trig=01", n, trig, GAP_CYC + 1); end
    endtask

    task automatic test_basic();
        int lat, tw, nv, n;
        run_echo(0, 1000, 1'b0, lat, tw, nv);
        checks++; if (nv !== 1 || dist_ch !== 1'b0) begin errors++; $display("FAIL basic_strobe got nv=%0d ch=%0d exp 1/0", nv, dist_ch); end
        checks++; if (fld(0) !== 8'h17 || err[0] !== 1'b0) begin errors++; $display("FAIL basic_field got %h err=%b exp 17/0", fld(0), err[0]); end
        checks++; if (tw !== TRIG_CYC) begin errors++; $display("FAIL basic_trig_width got %0d exp %0d", tw, TRIG_CYC); end
        checks++; if (lat !== 1000 + 5) begin errors++; $display("FAIL basic_vld_latency got %0d exp %0d", lat, 1005); end
        wait_trig(n);
        checks++; if (n !== GAP_CYC + 1 || trig !== 2'b10) begin errors++; $display("FAIL basic_next_trig got n=%0d trig=%b exp n=%0d trig=10", n, trig, GAP_CYC + 1); end
    endtask

    task automatic test_timeout();
        int lat, tw, nv;
        run_echo(1, 0, 1'b0, lat, tw, nv);
        checks++; if (tw !== TRIG_CYC) begin errors++; $display("FAIL timeout_trig1_width got %0d exp %0d", tw, TRIG_CYC); end
        checks++; if (nv !== 1 || lat !== TO_CYC + 1 || dist_ch !== 1'b1) begin errors++; $display("FAIL timeout_strobe got nv=%0d lat=%0d ch=%0d exp 1/%0d/1", nv, lat, dist_ch, TO_CYC + 1); end
        checks++; if (fld(1) !== 8'h99 || err[1] !== 1'b1) begin errors++; $display("FAIL timeout_field1 got %h err=%b exp 99/1", fld(1), err[1]); end
        checks++; if (fld(0) !== bcd_of(exp_cm[0]) || err[0] !== 1'b0) begin errors++; $display("FAIL timeout_field0_kept got %h exp %h", fld(0), bcd_of(exp_cm[0])); end
    endtask

    task automatic test_boundaries();
        int widths [4] = '{57, 58, 1160, 1300};
        int lat, tw, nv, ch;
        for (int i = 0; i < 4; i++) begin
            ch = i % 2;
            run_echo(ch, widths[i], 1'b0, lat, tw, nv);
            checks++; if (nv !== 1 || dist_ch !== 1'(ch)) begin errors++; $display("FAIL bound_strobe w=%0d got nv=%0d ch=%0d exp 1/%0d", widths[i], nv, dist_ch, ch); end
            checks++; if (fld(ch) !== bcd_of(exp_cm[ch]) || err[ch] !== (exp_cm[ch] < 0)) begin errors++; $display("FAIL bound_field w=%0d got %h err=%b exp %h", widths[i], fld(ch), err[ch], bcd_of(exp_cm[ch])); end
        end
    endtask

    task automatic test_random();
        int lat, tw, nv, ch, w;
        ch = 0;
        for (int i = 0; i < 6; i++) begin
            w = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1300));
            run_echo(ch, w, 1'($urandom_range(0, 1)), lat, tw, nv);
            checks++; if (nv !== 1 || dist_ch !== 1'(ch) || tw !== TRIG_CYC) begin errors++; $display("FAIL rand_strobe w=%0d got nv=%0d ch=%0d tw=%0d exp 1/%0d/%0d", w, nv, dist_ch, tw, ch, TRIG_CYC); end
            checks++; if (fld(ch) !== bcd_of(exp_cm[ch]) || err[ch] !== (exp_cm[ch] < 0)) begin errors++; $display("FAIL rand_field w=%0d got %h err=%b exp %h", w, fld(ch), err[ch], bcd_of(exp_cm[ch])); end
            if (w == 0) begin
                checks++; if (lat !== TO_CYC + 1) begin errors++; $display("FAIL rand_timeout_lat got %0d exp %0d", lat, TO_CYC + 1); end
            end
            ch = 1 - ch;
        end
    endtask

    task automatic test_stuck_high();
        int lat, tw, nv;
        echo[1] = 1'b1;
        do_reset(3);
        run_echo(0, 580, 1'b0, lat, tw, nv);
        checks++; if (fld(0) !== 8'h10 || dist_ch !== 1'b0) begin errors++; $display("FAIL stuck_ch0 got %h ch=%0d exp 10/0", fld(0), dist_ch); end
        run_echo(1, 0, 1'b0, lat, tw, nv);
        checks++; if (nv !== 1 || lat !== TO_CYC + 1 || fld(1) !== 8'h99 || err !== 2'b10) begin errors++; $display("FAIL stuck_ch1 got nv=%0d lat=%0d f=%h err=%b exp 1/%0d/99/10", nv, lat, fld(1), err, TO_CYC + 1); end
        checks++; if (fld(0) !== 8'h10) begin errors++; $display("FAIL stuck_field0_kept got %h exp 10", fld(0)); end
        echo[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, v0, lat, tw, nv;
        do_reset(3);
        wait_trig(n);
        while (trig != '0 && n < 7000) begin step(); n++; end
        step();
        echo[0] = 1'b1;
        repeat (500) step();
        v0 = vld_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < CH; k++) exp_cm[k] = 0;
        checks++; if (trig !== '0 || dist_vld !== 1'b0 || dist_bcd !== '0 || err !== '0 || dist_ch !== 1'b0) begin errors++; $display("FAIL midreset_outputs got trig=%b vld=%b bcd=%h err=%b ch=%0d exp all 0", trig, dist_vld, dist_bcd, err, dist_ch); end
        echo[0] = 1'b0;
        repeat (20) step();
        checks++; if (vld_cnt !== v0) begin errors++; $display("FAIL midreset_no_strobe got %0d strobes exp 0", vld_cnt - v0); end
        run_echo(0, 580, 1'b0, lat, tw, nv);
        checks++; if (nv !== 1 || dist_ch !== 1'b0 || fld(0) !== 8'h10) begin errors++; $display("FAIL midreset_followup got nv=%0d ch=%0d f=%h exp 1/0/10", nv, dist_ch, fld(0)); end
    endtask

    task automatic test_enable_crosstalk();
        int r0, n, lat, tw, nv;
        en = 1'b0;
        do_reset(3);
        r0 = trig_rises;
        repeat (5000) step();
        checks++; if (trig_rises !== r0 || trig !== '0) begin errors++; $display("FAIL en_low_no_trig got %0d rises exp 0", trig_rises - r0); end
        en = 1'b1;
        n = 0;
        while (trig == '0 && n < 20) begin step(); n++; end
        checks++; if (n !== 2 || trig !== 2'b01) begin errors++; $display("FAIL en_rise_trig got n=%0d trig=%b exp 2/01", n, trig); end
        run_echo(0, 700, 1'b1, lat, tw, nv);
        checks++; if (nv !== 1 || dist_ch !== 1'b0 || fld(0) !== 8'h12 || err[0] !== 1'b0) begin errors++; $display("FAIL crosstalk got nv=%0d ch=%0d f=%h err=%b exp 1/0/12/0", nv, dist_ch, fld(0), err[0]); end
    endtask

    initial begin
        for (int k = 0; k < CH; k++) exp_cm[k] = 0;
        test_reset();
        test_basic();
        test_timeout();
        test_boundaries();
        test_random();
        test_stuck_high();
        test_reset_mid();
        test_enable_crosstalk();
        checks++; if (multi_hot !== 0) begin errors++; $display("FAIL trig_onehot got %0d multi-hot cycles exp 0", multi_hot); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
